// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sequencer, its datapath and their benches.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH    = 4;
  localparam int unsigned GCD_ITER_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    RESP
  } gcd_state_e;

endpackage

// File: rtl/gcd_seq_ctrl.sv
// Control sequencer for gcd_datapath: accepts operand pairs, runs the
// subtract-until-equal loop and returns the result with error flag and count.
module gcd_seq_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH    = GCD_WIDTH,
  parameter int unsigned ITER_MAX = GCD_ITER_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             dp_rst,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_a_sel,
  output logic             dp_b_sel,
  output logic             dp_a_load,
  output logic             dp_b_load,
  output logic             dp_done,
  input  logic             dp_eq,
  input  logic             dp_bigger,
  input  logic [WIDTH-1:0] dp_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [3:0]       out_iters
);

  gcd_state_e       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_iters;
  logic             r_err;

  logic w_zero;
  logic w_cap;

  // A zero operand never converges in the datapath, so it is rejected up front.
  assign w_zero = (in_a == '0) || (in_b == '0);
  assign w_cap  = (r_iters == 4'(ITER_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_iters <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_iters <= '0;
            r_err   <= w_zero;
            r_state <= w_zero ? RESP : LOAD;
          end
        end
        LOAD: r_state <= CALC;
        CALC: begin
          if (dp_eq) begin
            r_state <= RESP;
          end else if (w_cap) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_iters <= r_iters + 4'd1;
          end
        end
        RESP: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath controls must act in the same cycle the flags are valid.
  always_comb begin
    dp_a_sel  = 1'b0;
    dp_b_sel  = 1'b0;
    dp_a_load = 1'b0;
    dp_b_load = 1'b0;
    dp_done   = 1'b0;
    if (!rst) begin
      case (r_state)
        LOAD: begin
          dp_a_load = 1'b1;
          dp_b_load = 1'b1;
        end
        CALC: begin
          if (dp_eq) begin
            dp_done = 1'b1;
          end else if (!w_cap) begin
            if (dp_bigger) begin
              dp_a_sel  = 1'b1;
              dp_a_load = 1'b1;
            end else begin
              dp_b_sel  = 1'b1;
              dp_b_load = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dp_rst    = rst;
  assign dp_a      = r_a;
  assign dp_b      = r_b;
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == RESP);
  assign out_gcd   = (out_valid && !r_err) ? dp_res : '0;
  assign out_err   = r_err;
  assign out_iters = r_iters;

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Directed bench for gcd_seq_ctrl with a behavioural gcd_datapath model.
module tb_gcd_seq_ctrl;
  import gcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       dp_rst;
  logic [3:0] dp_a, dp_b;
  logic       dp_a_sel, dp_b_sel, dp_a_load, dp_b_load, dp_done;
  logic       dp_eq, dp_bigger;
  logic [3:0] dp_res;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_gcd;
  logic       out_err;
  logic [3:0] out_iters;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc;
  int n_done = 0;
  int n_load = 0;

  always #5 clk = ~clk;

  gcd_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .dp_rst    (dp_rst),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_a_sel  (dp_a_sel),
    .dp_b_sel  (dp_b_sel),
    .dp_a_load (dp_a_load),
    .dp_b_load (dp_b_load),
    .dp_done   (dp_done),
    .dp_eq     (dp_eq),
    .dp_bigger (dp_bigger),
    .dp_res    (dp_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_err   (out_err),
    .out_iters (out_iters)
  );

  // Datapath model: a/b registers with subtract muxes and a result latch.
  logic [3:0] m_a = '0, m_b = '0, m_res = '0;
  always @(posedge clk) begin
    if (dp_rst) begin
      m_a <= '0; m_b <= '0; m_res <= '0;
    end else begin
      if (dp_a_load) m_a <= dp_a_sel ? m_a - m_b : dp_a;
      if (dp_b_load) m_b <= dp_b_sel ? m_b - m_a : dp_b;
      if (dp_done) m_res <= m_a;
    end
  end
  assign dp_eq     = (m_a == m_b);
  assign dp_bigger = (m_a > m_b);
  assign dp_res    = m_res;

  always @(posedge clk) begin
    if (dp_done) n_done++;
    if (dp_a_load || dp_b_load) n_load++;
  end

  task automatic start_job(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 40);
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_valid, out_err, out_iters, out_gcd} !== 10'd0) $display("FAIL reset_outputs got v=%b e=%b it=%0d g=%0d want all 0", out_valid, out_err, out_iters, out_gcd);
    else pass_cnt++;
    total_cnt++;
    if ({dp_a_sel, dp_b_sel, dp_a_load, dp_b_load, dp_done} !== 5'b0) $display("FAIL reset_dp_ctrl got %b want 00000", {dp_a_sel, dp_b_sel, dp_a_load, dp_b_load, dp_done});
    else pass_cnt++;
    total_cnt++;
    if (dp_rst !== 1'b1) $display("FAIL reset_dp_rst got %b want 1", dp_rst);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (dp_rst !== 1'b0 || in_ready !== 1'b1) $display("FAIL post_reset got dp_rst=%b in_ready=%b want 0/1", dp_rst, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int d0 = n_done;
    start_job(4'd12, 4'd8);
    wait_valid();
    total_cnt++;
    if (cyc !== 5) $display("FAIL basic_latency got %0d want 5", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({out_gcd, out_iters, out_err} !== {4'd4, 4'd2, 1'b0}) $display("FAIL basic_result got g=%0d it=%0d e=%b want 4/2/0", out_gcd, out_iters, out_err);
    else pass_cnt++;
    total_cnt++;
    if (n_done - d0 !== 1) $display("FAIL basic_done_pulses got %0d want 1", n_done - d0);
    else pass_cnt++;
    finish_job();
  endtask

  task automatic test_equal();
    start_job(4'd7, 4'd7);
    wait_valid();
    total_cnt++;
    if (cyc !== 3) $display("FAIL equal_latency got %0d want 3", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({out_gcd, out_iters, out_err} !== {4'd7, 4'd0, 1'b0}) $display("FAIL equal_result got g=%0d it=%0d e=%b want 7/0/0", out_gcd, out_iters, out_err);
    else pass_cnt++;
    finish_job();
  endtask

  task automatic test_long();
    start_job(4'd15, 4'd1);
    wait_valid();
    total_cnt++;
    if (cyc !== 17) $display("FAIL long_latency got %0d want 17", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({out_gcd, out_iters, out_err} !== {4'd1, 4'd14, 1'b0}) $display("FAIL long_result got g=%0d it=%0d e=%b want 1/14/0", out_gcd, out_iters, out_err);
    else pass_cnt++;
    finish_job();
  endtask

  task automatic test_zero();
    logic [3:0] va [2] = '{4'd0, 4'd5};
    logic [3:0] vb [2] = '{4'd5, 4'd0};
    for (int i = 0; i < 2; i++) begin
      int l0 = n_load;
      start_job(va[i], vb[i]);
      wait_valid();
      total_cnt++;
      if (cyc !== 1) $display("FAIL zero%0d_latency got %0d want 1", i, cyc);
      else pass_cnt++;
      total_cnt++;
      if ({out_gcd, out_err} !== {4'd0, 1'b1}) $display("FAIL zero%0d_result got g=%0d e=%b want 0/1", i, out_gcd, out_err);
      else pass_cnt++;
      finish_job();
      total_cnt++;
      if (n_load - l0 !== 0) $display("FAIL zero%0d_loads got %0d want 0", i, n_load - l0);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    start_job(4'd9, 4'd6);
    wait_valid();
    total_cnt++;
    if ({out_gcd, out_iters, out_err} !== {4'd3, 4'd2, 1'b0}) $display("FAIL bp_result got g=%0d it=%0d e=%b want 3/2/0", out_gcd, out_iters, out_err);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({out_valid, in_ready, out_gcd, out_iters, out_err} !== {1'b1, 1'b0, 4'd3, 4'd2, 1'b0})
        $display("FAIL bp_hold%0d got v=%b rdy=%b g=%0d it=%0d e=%b want 1/0/3/2/0", i, out_valid, in_ready, out_gcd, out_iters, out_err);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release got rdy=%b v=%b want 1/0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    start_job(4'd13, 4'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid, dp_res} !== {1'b1, 1'b0, 4'd0}) $display("FAIL midrst_abort got rdy=%b v=%b res=%0d want 1/0/0", in_ready, out_valid, dp_res);
    else pass_cnt++;
    rst = 1'b0;
    start_job(4'd6, 4'd4);
    wait_valid();
    total_cnt++;
    if ({out_gcd, out_iters, out_err} !== {4'd2, 4'd2, 1'b0}) $display("FAIL midrst_next got g=%0d it=%0d e=%b want 2/2/0", out_gcd, out_iters, out_err);
    else pass_cnt++;
    finish_job();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_long();
    test_zero();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gcd_seq_ctrl.md
# gcd_seq_ctrl

Control sequencer that sits directly upstream of `gcd_datapath` and drives all of its control inputs. It accepts 4-bit operand pairs over a valid/ready handshake and runs the subtract-until-equal loop on the datapath. It returns the datapath's latched result with an error flag and an iteration count over a second valid/ready handshake. It is the only block permitted to drive the datapath's control pins.

## Interface
- `WIDTH`, 4: operand width; must match the datapath.
- `ITER_MAX`, 15: subtraction cap before abort.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  high only in IDLE.
- `in_a`, `in_b`  in  WIDTH  operands.
- `dp_rst`  out  1  equals `rst` (combinational pass-through).
- `dp_a`, `dp_b`  out  WIDTH  captured operands to the datapath A/B inputs.
- `dp_a_sel`, `dp_b_sel`, `dp_a_load`, `dp_b_load`, `dp_done`  out  1  datapath controls.
- `dp_eq`, `dp_bigger`  in  1  datapath flags (a==b, a>b).
- `dp_res`  in  WIDTH  datapath result register.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `out_gcd`  out  WIDTH  result; equals `dp_res` in RESP.
- `out_err`  out  1  zero operand or cap hit.
- `out_iters`  out  4  subtractions performed.

## Operation
- States: IDLE, LOAD, CALC, RESP.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture `in_a`/`in_b` into operand regs and clear the iteration count.
  - If either operand is 0, go to RESP with err=1 and gcd=0. Zero operands would loop forever in the datapath.
  - Otherwise go to LOAD.
- **LOAD**
  - Drive sel_a=sel_b=0 and load_a=load_b=1. This loads the captured operands into the datapath.
  - Go to CALC.
- **CALC** (flags reflect the registered a, b)
  - `dp_eq`: assert `dp_done` for one cycle and go to RESP.
  - `dp_bigger`: sel_a=1, load_a=1 (a←a−b), iters+1.
  - Otherwise: sel_b=1, load_b=1 (b←b−a), iters+1.
  - If iters==ITER_MAX and not `dp_eq`: set err=1 and go to RESP without asserting done.
- **RESP**
  - `out_valid`=1. Hold `out_gcd`, `out_err` and `out_iters` stable until `out_ready`, then go to IDLE.
  - `out_gcd` = `dp_res` when err=0, and 0 when err=1.
- All datapath controls not named above are 0. `dp_done` is never high outside CALC.
- Reset values:
  - State is IDLE.
  - `out_valid`=0, `out_err`=0, `out_iters`=0, `out_gcd`=0.
  - All dp controls are 0; `dp_rst`=1 while reset is held.
- Reset mid-operation aborts to IDLE with no response. The datapath is cleared through `dp_rst`.
- Input arriving while not IDLE is ignored (`in_ready`=0). There is no buffering.
- `out_ready` is ignored outside RESP.

## Timing
- Acceptance edge = edge 0.
- Zero operand: `out_valid` is high in the cycle after edge 0.
- Nonzero operands: LOAD occupies cycle 1, and CALC starts in cycle 2.
  - CALC lasts iters+1 cycles.
  - `out_valid` rises in cycle iters+3.
- Back-to-back: a new pair is accepted in the cycle after the RESP handshake completes. Minimum occupancy is 4 cycles per nonzero job.

## Structure
- Shared package `gcd_pkg`:
  - state enum: IDLE, LOAD, CALC, RESP.
  - `GCD_WIDTH`=4.
  - `GCD_ITER_MAX`=15.
  - This package is shared with the datapath and its bench.
- Single module with no sub-modules. The operand capture, iteration counter and FSM are flat logic.

## Test plan
- (12,8), `out_ready`=1 → gcd=4, iters=2, err=0; `out_valid` in cycle 5; `dp_done` pulses once.
- (7,7) → gcd=7, iters=0; `out_valid` in cycle 3.
- (15,1) → gcd=1, iters=14, err=0; `out_valid` in cycle 17.
- (0,5) and (5,0) → err=1, gcd=0; `out_valid` in cycle 1; the datapath load controls never assert.
- (9,6) with `out_ready` held low 3 cycles in RESP → outputs stable and `in_ready`=0 throughout; IDLE is entered the cycle after `out_ready` rises.
- `rst` asserted during CALC of (13,3) → next cycle IDLE, `out_valid`=0, `dp_res`=0; a following (6,4) returns gcd=2.
